fp_pack_special: RTL and testbench



---
 rtl/fp_pack_pkg.sv | 16 +
 rtl/fp_round_rne.sv | 21 ++
 rtl/fp_pack_special.sv | 162 ++++++++++++++++
 tb/tb_fp_pack_special.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/fp_pack_pkg.sv
// Shared types and constants for the single-precision result packer.
package fp_pack_pkg;

    typedef enum logic [1:0] {StIdle, StNorm, StRound, StOut} state_e;

    localparam int unsigned MANT_W = 28;
    localparam int unsigned SIG_W  = 24;
    localparam int unsigned GRS_W  = 3;
    localparam int unsigned EXP_W  = 11;

    localparam int          BIAS     = 127;
    localparam int          EXP_INF  = 255;
    localparam logic [31:0] QNAN     = 32'h7FC0_0000;
    localparam logic [30:0] INF_BITS = 31'h7F80_0000;

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even increment on a 24-bit significand with guard/round/sticky bits.
module fp_round_rne
    import fp_pack_pkg::*;
(
    input  logic [SIG_W-1:0] sig_i,
    input  logic [GRS_W-1:0] grs_i,
    output logic [SIG_W:0]   sum_o,
    output logic             carry_o,
    output logic             inexact_o
);

    logic inc;

    always_comb begin
        inc       = grs_i[2] & (grs_i[1] | grs_i[0] | sig_i[0]);
        sum_o     = {1'b0, sig_i} + {{SIG_W{1'b0}}, inc};
        carry_o   = sum_o[SIG_W];
        inexact_o = |grs_i;
    end

endmodule

// File: rtl/fp_pack_special.sv
// Sequential IEEE-754 single packer: bit-serial normalise, RNE round, special encodings.
// Define FP_PACK_DENORM_EN for gradual underflow; otherwise tiny results flush to zero.
module fp_pack_special
    import fp_pack_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              in_sign_i,
    input  logic [9:0]        in_exp_i,
    input  logic [MANT_W-1:0] in_mant_i,
    input  logic              in_nan_i,
    input  logic              in_inf_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [31:0]       out_data_o,
    output logic              out_ovf_o,
    output logic              out_unf_o,
    output logic              out_inx_o
);

    state_e                   state_q, state_d;
    logic                     sign_q, sign_d;
    logic signed [EXP_W-1:0]  exp_q, exp_d;
    logic [MANT_W-1:0]        mant_q, mant_d;
    logic [31:0]              data_q, data_d;
    logic                     ovf_q, ovf_d, unf_q, unf_d, inx_q, inx_d;

    logic [SIG_W:0]           rnd_sum;
    logic                     rnd_carry, rnd_inexact;
    logic [SIG_W-1:0]         sig_r;
    logic signed [EXP_W-1:0]  exp_r;
    logic [7:0]               field_r;

    fp_round_rne u_round (
        .sig_i     (mant_q[26:3]),
        .grs_i     (mant_q[2:0]),
        .sum_o     (rnd_sum),
        .carry_o   (rnd_carry),
        .inexact_o (rnd_inexact)
    );

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        exp_d   = exp_q;
        mant_d  = mant_q;
        data_d  = data_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        inx_d   = inx_q;
        sig_r   = rnd_carry ? rnd_sum[SIG_W:1] : rnd_sum[SIG_W-1:0];
        exp_r   = exp_q + (rnd_carry ? EXP_W'(1) : EXP_W'(0));
        field_r = sig_r[SIG_W-1] ? exp_r[7:0] : 8'd0;

        unique case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    ovf_d = 1'b0;
                    unf_d = 1'b0;
                    inx_d = 1'b0;
                    if (in_nan_i) begin
                        data_d  = QNAN;
                        state_d = StOut;
                    end else if (in_inf_i) begin
                        data_d  = {in_sign_i, INF_BITS};
                        state_d = StOut;
                    end else if (in_mant_i == '0) begin
                        data_d  = {in_sign_i, 31'b0};
                        state_d = StOut;
                    end else begin
                        sign_d  = in_sign_i;
                        exp_d   = {in_exp_i[9], in_exp_i};
                        mant_d  = in_mant_i;
                        state_d = StNorm;
                    end
                end
            end
            StNorm: begin
                // Right shifts fold the dropped bit into sticky so inexact is never lost.
                if (mant_q[27]) begin
                    mant_d = {1'b0, mant_q[27:2], mant_q[1] | mant_q[0]};
                    exp_d  = exp_q + EXP_W'(1);
`ifdef FP_PACK_DENORM_EN
                end else if (exp_q < -26) begin
                    mant_d = {27'b0, |mant_q};
                    exp_d  = EXP_W'(1);
                end else if (exp_q < 1) begin
                    mant_d = {1'b0, mant_q[27:2], mant_q[1] | mant_q[0]};
                    exp_d  = exp_q + EXP_W'(1);
`else
                end else if (exp_q < 1) begin
                    state_d = StRound;
`endif
                end else if (!mant_q[26] && exp_q > 1) begin
                    mant_d = {mant_q[26:0], 1'b0};
                    exp_d  = exp_q - EXP_W'(1);
                end else begin
                    state_d = StRound;
                end
            end
            StRound: begin
                state_d = StOut;
                if (exp_r >= EXP_INF) begin
                    data_d = {sign_q, INF_BITS};
                    ovf_d  = 1'b1;
                    unf_d  = 1'b0;
                    inx_d  = 1'b1;
`ifndef FP_PACK_DENORM_EN
                end else if (exp_q < 1 || !sig_r[SIG_W-1]) begin
                    data_d = {sign_q, 31'b0};
                    ovf_d  = 1'b0;
                    unf_d  = 1'b1;
                    inx_d  = 1'b1;
`endif
                end else begin
                    data_d = {sign_q, field_r, sig_r[SIG_W-2:0]};
                    ovf_d  = 1'b0;
                    unf_d  = (field_r == 8'd0) & rnd_inexact;
                    inx_d  = rnd_inexact;
                end
            end
            StOut: begin
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            mant_q  <= '0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            inx_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            mant_q  <= mant_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            inx_q   <= inx_d;
        end
    end

    assign in_ready_o  = (state_q == StIdle) & rst_n;
    assign out_valid_o = (state_q == StOut);
    assign out_data_o  = data_q;
    assign out_ovf_o   = ovf_q;
    assign out_unf_o   = unf_q;
    assign out_inx_o   = inx_q;

endmodule

// File: tb/tb_fp_pack_special.sv
// Directed bench for fp_pack_special: scoreboard of expected words, latency and flags.
module tb_fp_pack_special;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [9:0]  in_exp = '0;
    logic [27:0] in_mant = '0;
    logic        in_nan = 1'b0;
    logic        in_inf = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_ovf, out_unf, out_inx;

    always #5 clk = ~clk;

    fp_pack_special dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_sign_i   (in_sign),
        .in_exp_i    (in_exp),
        .in_mant_i   (in_mant),
        .in_nan_i    (in_nan),
        .in_inf_i    (in_inf),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_ovf_o   (out_ovf),
        .out_unf_o   (out_unf),
        .out_inx_o   (out_inx)
    );

    typedef struct {
        logic [31:0] data;
        logic        ovf;
        logic        unf;
        logic        inx;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic run(input string tag, input logic s, input logic [9:0] e,
                       input logic [27:0] m, input logic nan, input logic inf,
                       input logic [31:0] d, input logic ovf, input logic unf,
                       input logic inx, input int lat, input int hold);
        exp_t x;
        exp_t got;
        int   l;
        x.data = d; x.ovf = ovf; x.unf = unf; x.inx = inx; x.lat = lat;
        sb.push_back(x);
        check({tag, "/in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_sign = s; in_exp = e; in_mant = m; in_nan = nan; in_inf = inf;
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_nan = 1'b0; in_inf = 1'b0;
        l = 1;
        while (out_valid !== 1'b1 && l < 200) begin
            @(posedge clk);
            #1;
            l++;
        end
        check({tag, "/valid"}, 32'(out_valid), 32'd1);
        got = sb.pop_front();
        check({tag, "/lat"}, 32'(l), 32'(got.lat));
        check({tag, "/data"}, out_data, got.data);
        check({tag, "/flags"}, {29'b0, out_ovf, out_unf, out_inx},
              {29'b0, got.ovf, got.unf, got.inx});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, "/hold_data"}, out_data, got.data);
            check({tag, "/hold_busy"}, {30'b0, out_valid, in_ready}, 32'b10);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "/release"}, {30'b0, out_valid, in_ready}, 32'b01);
    endtask

    initial begin
        #2;
        check("reset/out", {out_data[31:3], out_ovf, out_unf, out_inx}, 32'd0);
        check("reset/hs", {30'b0, out_valid, in_ready}, 32'b00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("reset/ready", 32'(in_ready), 32'd1);

        run("nan_inf", 1'b1, 10'd0, 28'h0, 1'b1, 1'b1, 32'h7FC0_0000, 0, 0, 0, 1, 0);
        run("neg_inf", 1'b1, 10'd0, 28'h0, 1'b0, 1'b1, 32'hFF80_0000, 0, 0, 0, 1, 0);
        run("neg_zero", 1'b1, 10'd50, 28'h0, 1'b0, 1'b0, 32'h8000_0000, 0, 0, 0, 1, 0);
        run("neg_one", 1'b1, 10'd127, 28'h400_0000, 0, 0, 32'hBF80_0000, 0, 0, 0, 3, 0);
        run("lshift3", 1'b0, 10'd127, 28'h080_0000, 0, 0, 32'h3E00_0000, 0, 0, 0, 6, 5);
        run("carry", 1'b0, 10'd127, 28'h800_0000, 0, 0, 32'h4000_0000, 0, 0, 0, 4, 0);
        run("sticky", 1'b0, 10'd127, 28'h800_0009, 0, 0, 32'h4000_0001, 0, 0, 1, 4, 0);
        run("ovf", 1'b0, 10'd254, 28'h7FF_FFFF, 0, 0, 32'h7F80_0000, 1, 0, 1, 3, 0);
        run("tie_even", 1'b0, 10'd127, 28'h400_0004, 0, 0, 32'h3F80_0000, 0, 0, 1, 3, 0);
        run("tie_odd", 1'b0, 10'd127, 28'h400_000C, 0, 0, 32'h3F80_0002, 0, 0, 1, 3, 0);
`ifdef FP_PACK_DENORM_EN
        run("tiny", 1'b0, 10'd0, 28'h400_0000, 0, 0, 32'h0040_0000, 0, 0, 0, 4, 0);
        run("deep", 1'b1, 10'h39C, 28'h400_0000, 0, 0, 32'h8000_0000, 0, 1, 1, 4, 0);
`else
        run("tiny", 1'b0, 10'd0, 28'h400_0000, 0, 0, 32'h0000_0000, 0, 1, 1, 3, 0);
        run("deep", 1'b1, 10'h39C, 28'h400_0000, 0, 0, 32'h8000_0000, 0, 1, 1, 3, 0);
`endif

        // Abort an operation while it is still normalising.
        in_valid = 1'b1; in_sign = 1'b0; in_exp = 10'd127; in_mant = 28'h080_0000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst/hs", {30'b0, out_valid, in_ready}, 32'b00);
        check("midrst/data", out_data, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("midrst/ready", 32'(in_ready), 32'd1);
        repeat (8) @(posedge clk);
        #1;
        check("midrst/no_out", 32'(out_valid), 32'd0);
        run("after_rst", 1'b0, 10'd128, 28'h400_0000, 0, 0, 32'h4000_0000, 0, 0, 0, 3, 0);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
